// File: rtl/scope_pingpong_buffer.sv
// Ping-pong capture/display buffer: the producer fills one bank while the LCD scan reads the other.
// Optional macro SCOPE_BUF_FREEZE_EN adds a hold input that freezes the displayed record.
module scope_pingpong_buffer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int CH_NUM      = 2,
    parameter int DIS_X_START = 0,
    parameter int DIS_X_END   = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [CH_NUM*DATA_W-1:0]   wr_data,
    output logic                       wr_ready,
    input  logic                       frame_start,
    input  logic [10:0]                x_pos,
`ifdef SCOPE_BUF_FREEZE_EN
    input  logic                       hold,
`endif
    output logic [CH_NUM*DATA_W-1:0]   rd_data,
    output logic                       rd_hit,
    output logic                       bank_sel,
    output logic                       swap_pulse,
    output logic                       frame_miss
);
    localparam int WORD_W = CH_NUM * DATA_W;

    typedef enum logic {FILL, FULL} wr_state_t;

`ifndef SCOPE_BUF_FREEZE_EN
    logic hold;
    assign hold = 1'b0;
`endif

    wr_state_t           state_reg, state_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic                bank_sel_reg, bank_sel_next;
    logic                disp_valid_reg, disp_valid_next;
    logic                swap_pulse_reg, swap_pulse_next;
    logic                frame_miss_reg, frame_miss_next;
    logic                wr_en;

    assign wr_ready = (state_reg == FILL);
    assign wr_en    = wr_valid & wr_ready & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL;
            wr_addr_reg    <= '0;
            bank_sel_reg   <= 1'b0;
            disp_valid_reg <= 1'b0;
            swap_pulse_reg <= 1'b0;
            frame_miss_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_addr_reg    <= wr_addr_next;
            bank_sel_reg   <= bank_sel_next;
            disp_valid_reg <= disp_valid_next;
            swap_pulse_reg <= swap_pulse_next;
            frame_miss_reg <= frame_miss_next;
        end
    end

    // The frame_start decision looks only at state_reg, so a last write landing in the
    // same cycle as frame_start still counts as a miss and the swap waits a frame.
    always_comb begin
        state_next      = state_reg;
        wr_addr_next    = wr_addr_reg;
        bank_sel_next   = bank_sel_reg;
        disp_valid_next = disp_valid_reg;
        swap_pulse_next = 1'b0;
        frame_miss_next = 1'b0;
        if (wr_en) begin
            if (wr_addr_reg == ADDR_W'(DEPTH - 1)) begin
                wr_addr_next = '0;
                state_next   = FULL;
            end else begin
                wr_addr_next = wr_addr_reg + 1'b1;
            end
        end
        if (frame_start) begin
            if (state_reg == FULL && !hold) begin
                bank_sel_next   = ~bank_sel_reg;
                disp_valid_next = 1'b1;
                swap_pulse_next = 1'b1;
                state_next      = FILL;
                wr_addr_next    = '0;
            end else if (state_reg == FILL) begin
                frame_miss_next = 1'b1;
            end
        end
    end

    // Read address and window decode
    logic [31:0]       x_ext, idx_full;
    logic [ADDR_W-1:0] rd_idx;
    logic              in_window;

    assign x_ext     = {21'd0, x_pos};
    assign idx_full  = x_ext - 32'(DIS_X_START);
    assign rd_idx    = idx_full[ADDR_W-1:0];
    assign in_window = (x_ext >= 32'(DIS_X_START)) && (x_ext <= 32'(DIS_X_END))
                       && (idx_full < 32'(DEPTH));

    logic hit_reg, sel_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_reg <= 1'b0;
            sel_reg <= 1'b0;
        end else begin
            hit_reg <= in_window & disp_valid_reg;
            sel_reg <= bank_sel_reg;
        end
    end

    // Each bank is single-ported: the write bank is addressed by the writer,
    // the display bank by the scan position.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [WORD_W-1:0] mem [DEPTH];
            logic [WORD_W-1:0] rd_q;
            logic              is_wr_bank;
            logic [ADDR_W-1:0] addr;

            assign is_wr_bank = (bank_sel_reg != 1'(gi));
            assign addr       = is_wr_bank ? wr_addr_reg : rd_idx;

            always_ff @(posedge clk) begin
                if (is_wr_bank && wr_en)
                    mem[addr] <= wr_data;
                rd_q <= mem[addr];
            end
        end
    endgenerate

    assign rd_data    = !hit_reg ? '0 : (sel_reg ? g_bank[1].rd_q : g_bank[0].rd_q);
    assign rd_hit     = hit_reg;
    assign bank_sel   = bank_sel_reg;
    assign swap_pulse = swap_pulse_reg;
    assign frame_miss = frame_miss_reg;

endmodule
